// File: rtl/vp_recovery_ctrl.sv
// ----------------------------------------------------------------------------
// vp_recovery_ctrl
// Responder side of the value-prediction recovery handshake. A prediction
// opens a speculation window; every speculative register writeback during the
// window logs the register's previous value on an undo stack. On a
// misprediction the stack is unwound LIFO into the register file, the pipeline
// is flushed, fetch is redirected to the predicted load's PC and a one-cycle
// completion pulse is returned. A confirmed prediction simply discards the log.
// All outputs are registered and reflect the FSM state of the previous cycle.
// ----------------------------------------------------------------------------
module vp_recovery_ctrl #(
   parameter int LOG_DEPTH     = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 32,
   parameter int REG_IDX_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     spec_start,
   input  logic [ADDR_WIDTH-1:0]    spec_pc,
   input  logic                     recover,
   input  logic                     correct,
   input  logic                     wb_valid,
   input  logic [REG_IDX_WIDTH-1:0] wb_reg,
   input  logic [DATA_WIDTH-1:0]    wb_old_data,
   output logic                     rf_restore_valid,
   output logic [REG_IDX_WIDTH-1:0] rf_restore_reg,
   output logic [DATA_WIDTH-1:0]    rf_restore_data,
   output logic                     flush,
   output logic                     redirect_valid,
   output logic [ADDR_WIDTH-1:0]    redirect_pc,
   output logic                     recovery_done,
   output logic                     spec_active,
   output logic                     log_full,
   output logic                     log_overflow
);

   localparam int PTR_W = $clog2(LOG_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LOG_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SPEC,
      ST_UNDO,
      ST_REDIRECT,
      ST_DONE
   } state_e;

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [PTR_W-1:0]         ptr_q, ptr_d;     // next free slot; top of stack is ptr_q-1
   logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
   logic                     overflow_q, overflow_d;

   logic                     restore_valid_q, restore_valid_d;
   logic [REG_IDX_WIDTH-1:0] restore_reg_q, restore_reg_d;
   logic [DATA_WIDTH-1:0]    restore_data_q, restore_data_d;
   logic                     flush_q, flush_d;
   logic                     redirect_valid_q, redirect_valid_d;
   logic [ADDR_WIDTH-1:0]    redirect_pc_q, redirect_pc_d;
   logic                     done_q, done_d;
   logic                     spec_active_q, spec_active_d;
   logic                     log_full_q, log_full_d;

   // Undo stack storage: one register index and one old value per entry.
   logic [REG_IDX_WIDTH-1:0] log_reg_mem  [LOG_DEPTH];
   logic [DATA_WIDTH-1:0]    log_data_mem [LOG_DEPTH];

   logic                     push_en;
   logic [PTR_W-1:0]         top_ptr;
   logic                     stack_full;

   assign top_ptr    = ptr_q - PTR_ONE;   // wraps mod LOG_DEPTH
   assign stack_full = (count_q == FULL_CNT);

   // Next-state, stack bookkeeping and next-cycle output values.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path can
      // leave one unassigned, which would otherwise infer a latch.
      state_d          = state_q;
      count_d          = count_q;
      ptr_d            = ptr_q;
      pc_d             = pc_q;
      overflow_d       = overflow_q;
      push_en          = 1'b0;
      restore_valid_d  = 1'b0;
      restore_reg_d    = '0;
      restore_data_d   = '0;
      flush_d          = 1'b0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = '0;
      done_d           = 1'b0;
      spec_active_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (spec_start) begin
               state_d = ST_SPEC;
               pc_d    = spec_pc;
               count_d = '0;
               ptr_d   = '0;
            end
         end

         ST_SPEC: begin
            spec_active_d = 1'b1;
            if (recover) begin
               // A same-cycle writeback already modified the RF, so log it
               // before unwinding. recover takes priority over correct.
               if (wb_valid) begin
                  if (!stack_full) begin
                     push_en = 1'b1;
                     count_d = count_q + CNT_ONE;
                     ptr_d   = ptr_q + PTR_ONE;
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
               // Nothing to unwind: skip straight to the redirect.
               state_d = (count_q == '0 && !push_en) ? ST_REDIRECT : ST_UNDO;
            end else if (correct) begin
               state_d = ST_IDLE;
               count_d = '0;
               ptr_d   = '0;
            end else if (wb_valid) begin
               if (!stack_full) begin
                  push_en = 1'b1;
                  count_d = count_q + CNT_ONE;
                  ptr_d   = ptr_q + PTR_ONE;
               end else begin
                  overflow_d = 1'b1;
               end
            end
         end

         ST_UNDO: begin
            spec_active_d = 1'b1;
            flush_d       = 1'b1;
            if (count_q != '0) begin
               restore_valid_d = 1'b1;
               restore_reg_d   = log_reg_mem[top_ptr];
               restore_data_d  = log_data_mem[top_ptr];
               count_d         = count_q - CNT_ONE;
               ptr_d           = top_ptr;
               if (count_q == CNT_ONE) begin
                  state_d = ST_REDIRECT;
               end
            end else begin
               state_d = ST_REDIRECT;
            end
         end

         ST_REDIRECT: begin
            spec_active_d    = 1'b1;
            flush_d          = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = pc_q;
            state_d          = ST_DONE;
         end

         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      log_full_d = (count_d == FULL_CNT);
   end

   // State, stack bookkeeping and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         count_q          <= '0;
         ptr_q            <= '0;
         pc_q             <= '0;
         overflow_q       <= 1'b0;
         restore_valid_q  <= 1'b0;
         restore_reg_q    <= '0;
         restore_data_q   <= '0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         done_q           <= 1'b0;
         spec_active_q    <= 1'b0;
         log_full_q       <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         state_q          <= state_d;
         count_q          <= count_d;
         ptr_q            <= ptr_d;
         pc_q             <= pc_d;
         overflow_q       <= overflow_d;
         restore_valid_q  <= restore_valid_d;
         restore_reg_q    <= restore_reg_d;
         restore_data_q   <= restore_data_d;
         flush_q          <= flush_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         done_q           <= done_d;
         spec_active_q    <= spec_active_d;
         log_full_q       <= log_full_d;
      end
   end

   // Undo stack write port.
   // NOTE: the storage array has no reset; entries are only read below the
   // count, which is reset, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push_en) begin
         log_reg_mem[ptr_q]  <= wb_reg;
         log_data_mem[ptr_q] <= wb_old_data;
      end
   end

   assign rf_restore_valid = restore_valid_q;
   assign rf_restore_reg   = restore_reg_q;
   assign rf_restore_data  = restore_data_q;
   assign flush            = flush_q;
   assign redirect_valid   = redirect_valid_q;
   assign redirect_pc      = redirect_pc_q;
   assign recovery_done    = done_q;
   assign spec_active      = spec_active_q;
   assign log_full         = log_full_q;
   assign log_overflow     = overflow_q;

endmodule

// File: tb/tb_vp_recovery_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vp_recovery_ctrl
// Directed bench for vp_recovery_ctrl with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, i.e. they show the effect of the edge just taken.
// ----------------------------------------------------------------------------
module tb_vp_recovery_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        spec_start;
   logic [31:0] spec_pc;
   logic        recover;
   logic        correct;
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic [31:0] wb_old_data;
   logic        rf_restore_valid;
   logic [4:0]  rf_restore_reg;
   logic [31:0] rf_restore_data;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        recovery_done;
   logic        spec_active;
   logic        log_full;
   logic        log_overflow;

   int n_checks = 0;
   int n_fail   = 0;

   vp_recovery_ctrl #(
      .LOG_DEPTH     (8),
      .DATA_WIDTH    (32),
      .ADDR_WIDTH    (32),
      .REG_IDX_WIDTH (5)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .spec_start       (spec_start),
      .spec_pc          (spec_pc),
      .recover          (recover),
      .correct          (correct),
      .wb_valid         (wb_valid),
      .wb_reg           (wb_reg),
      .wb_old_data      (wb_old_data),
      .rf_restore_valid (rf_restore_valid),
      .rf_restore_reg   (rf_restore_reg),
      .rf_restore_data  (rf_restore_data),
      .flush            (flush),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .recovery_done    (recovery_done),
      .spec_active      (spec_active),
      .log_full         (log_full),
      .log_overflow     (log_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_push(input logic [4:0] r, input logic [31:0] d);
      wb_valid    = 1'b1;
      wb_reg      = r;
      wb_old_data = d;
      step();
      wb_valid    = 1'b0;
   endtask

   // Checks the handshake outputs for one cycle; reg/data and pc only matter
   // when their strobe is expected high.
   task automatic expect_cycle(input string tag, input logic rv, input logic [4:0] rr,
                               input logic [31:0] rd, input logic fl, input logic rdv,
                               input logic [31:0] rpc, input logic dn);
      check({tag, ".restore_valid"}, rf_restore_valid, rv);
      if (rv) begin
         check({tag, ".restore_reg"}, rf_restore_reg, rr);
         check({tag, ".restore_data"}, rf_restore_data, rd);
      end
      check({tag, ".flush"}, flush, fl);
      check({tag, ".redirect_valid"}, redirect_valid, rdv);
      if (rdv) check({tag, ".redirect_pc"}, redirect_pc, rpc);
      check({tag, ".recovery_done"}, recovery_done, dn);
   endtask

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n_rest;
      logic seen_redirect;

      rst = 1'b1; spec_start = 1'b0; spec_pc = '0; recover = 1'b0; correct = 1'b0;
      wb_valid = 1'b0; wb_reg = '0; wb_old_data = '0;

      // ---------------- Reset state ----------------
      step(); step();
      expect_cycle("rst", 0, 0, 0, 0, 0, 0, 0);
      check("rst.spec_active", spec_active, 0);
      check("rst.log_full", log_full, 0);
      check("rst.log_overflow", log_overflow, 0);
      rst = 1'b0;
      step();
      expect_cycle("post_rst", 0, 0, 0, 0, 0, 0, 0);

      // ---------------- Correct path ----------------
      spec_pc = 32'h0040_0010; spec_start = 1'b1;
      step();
      spec_start = 1'b0;
      check("corr.spec_active_s", spec_active, 0);
      wb_push(5'd1, 32'hAA);
      check("corr.spec_active_s1", spec_active, 1);
      wb_push(5'd2, 32'hBB);
      correct = 1'b1;
      step();
      correct = 1'b0;
      expect_cycle("corr.c", 0, 0, 0, 0, 0, 0, 0);
      step();
      expect_cycle("corr.c1", 0, 0, 0, 0, 0, 0, 0);
      check("corr.spec_active_c1", spec_active, 0);
      check("corr.log_full", log_full, 0);
      // IDLE ignores recover and writebacks.
      recover = 1'b1; wb_valid = 1'b1; wb_reg = 5'd9; wb_old_data = 32'h99;
      step();
      recover = 1'b0; wb_valid = 1'b0;
      step();
      expect_cycle("idle_ign", 0, 0, 0, 0, 0, 0, 0);
      check("idle_ign.spec_active", spec_active, 0);
      step();
      expect_cycle("idle_ign2", 0, 0, 0, 0, 0, 0, 0);

      // ---------------- Mispredict with 3 entries ----------------
      spec_pc = 32'h0040_0010; spec_start = 1'b1;
      step();
      spec_start = 1'b0;
      wb_push(5'd4, 32'h11);
      wb_push(5'd5, 32'h22);
      wb_push(5'd4, 32'h33);
      recover = 1'b1;
      step();                                     // edge T
      recover = 1'b0;
      expect_cycle("mis.T", 0, 0, 0, 0, 0, 0, 0);
      step(); expect_cycle("mis.T1", 1, 5'd4, 32'h33, 1, 0, 0, 0);
      step(); expect_cycle("mis.T2", 1, 5'd5, 32'h22, 1, 0, 0, 0);
      step(); expect_cycle("mis.T3", 1, 5'd4, 32'h11, 1, 0, 0, 0);
      step(); expect_cycle("mis.T4", 0, 0, 0, 1, 1, 32'h0040_0010, 0);
      check("mis.T4.spec_active", spec_active, 1);
      step(); expect_cycle("mis.T5", 0, 0, 0, 0, 0, 0, 1);
      check("mis.T5.spec_active", spec_active, 0);
      step(); expect_cycle("mis.T6", 0, 0, 0, 0, 0, 0, 0);

      // ---------------- Empty log ----------------
      spec_pc = 32'h1234_5678; spec_start = 1'b1;
      step();
      spec_start = 1'b0;
      recover = 1'b1;
      step();                                     // edge T
      recover = 1'b0;
      expect_cycle("empty.T", 0, 0, 0, 0, 0, 0, 0);
      step(); expect_cycle("empty.T1", 0, 0, 0, 1, 1, 32'h1234_5678, 0);
      step(); expect_cycle("empty.T2", 0, 0, 0, 0, 0, 0, 1);
      step(); expect_cycle("empty.T3", 0, 0, 0, 0, 0, 0, 0);

      // ---------------- recover + correct + wb in the same cycle ----------------
      spec_pc = 32'h0000_0ABC; spec_start = 1'b1;
      step();
      spec_start = 1'b0;
      wb_push(5'd2, 32'h5);
      recover = 1'b1; correct = 1'b1;
      wb_valid = 1'b1; wb_reg = 5'd7; wb_old_data = 32'h77;
      step();                                     // edge T
      recover = 1'b0; correct = 1'b0; wb_valid = 1'b0;
      step(); expect_cycle("sim.T1", 1, 5'd7, 32'h77, 1, 0, 0, 0);
      step(); expect_cycle("sim.T2", 1, 5'd2, 32'h5, 1, 0, 0, 0);
      step(); expect_cycle("sim.T3", 0, 0, 0, 1, 1, 32'h0000_0ABC, 0);
      step(); expect_cycle("sim.T4", 0, 0, 0, 0, 0, 0, 1);

      // ---------------- Full log and overflow ----------------
      spec_pc = 32'h0000_8000; spec_start = 1'b1;
      step();
      spec_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wb_push(5'(i), 32'h100 + 32'(i));
         check($sformatf("full.log_full_%0d", i), log_full, (i == 7));
      end
      check("full.overflow_before", log_overflow, 0);
      wb_push(5'd8, 32'h108);
      check("full.overflow_after", log_overflow, 1);
      check("full.log_full_9", log_full, 1);
      recover = 1'b1;
      step();                                     // edge T
      recover = 1'b0;
      n_rest = 0;
      seen_redirect = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (rf_restore_valid) begin
            check($sformatf("full.pop%0d.reg", n_rest), rf_restore_reg, 5'(7 - n_rest));
            check($sformatf("full.pop%0d.data", n_rest), rf_restore_data, 32'h107 - 32'(n_rest));
            n_rest++;
         end
         if (redirect_valid) begin
            seen_redirect = 1'b1;
            check("full.redirect_pc", redirect_pc, 32'h0000_8000);
            break;
         end
      end
      check("full.redirect_seen", seen_redirect, 1);
      check("full.restore_count", n_rest, 8);
      check("full.log_full_after_undo", log_full, 0);
      step();
      check("full.done", recovery_done, 1);
      check("full.overflow_sticky", log_overflow, 1);

      // ---------------- Reset in the middle of UNDO ----------------
      spec_pc = 32'h0000_0F00; spec_start = 1'b1;
      step();
      spec_start = 1'b0;
      wb_push(5'd1, 32'h1);
      wb_push(5'd2, 32'h2);
      wb_push(5'd3, 32'h3);
      recover = 1'b1;
      step();                                     // edge T
      recover = 1'b0;
      step(); expect_cycle("rstu.T1", 1, 5'd3, 32'h3, 1, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      expect_cycle("rstu.async", 0, 0, 0, 0, 0, 0, 0);
      check("rstu.spec_active", spec_active, 0);
      check("rstu.log_overflow", log_overflow, 0);
      check("rstu.log_full", log_full, 0);
      #1 rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         expect_cycle($sformatf("rstu.quiet%0d", k), 0, 0, 0, 0, 0, 0, 0);
      end
      spec_pc = 32'h0000_0200; spec_start = 1'b1;
      step();
      spec_start = 1'b0;
      step();
      check("rstu.new_spec_active", spec_active, 1);
      recover = 1'b1;
      step();
      recover = 1'b0;
      step(); expect_cycle("rstu.redirect", 0, 0, 0, 1, 1, 32'h0000_0200, 0);
      step(); expect_cycle("rstu.done", 0, 0, 0, 0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vp_recovery_ctrl.md
Name: vp_recovery_ctrl

Overview:
- Responder side of the value-prediction recovery handshake.
- Opens a speculation window when the value predictor issues a predicted load value.
- During the window, logs the old contents of every speculatively overwritten register in an undo stack.
- On `recover`: rolls the register file back in LIFO order, flushes, redirects fetch to the predicted load's PC, then pulses `recovery_done` back to the predictor. On `correct`: discards the log.

Parameters:
- LOG_DEPTH, 8, undo stack entries (power of 2, >=2)
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 32, PC width
- REG_IDX_WIDTH, 5, register index width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- spec_start  in  1  predictor issued a prediction (first-cycle out_valid); opens window
- spec_pc  in  ADDR_WIDTH  PC of predicted load, sampled with spec_start
- recover  in  1  misprediction pulse from predictor
- correct  in  1  prediction-confirmed pulse from predictor
- wb_valid  in  1  speculative register writeback this cycle
- wb_reg  in  REG_IDX_WIDTH  destination register of that writeback
- wb_old_data  in  DATA_WIDTH  value held by wb_reg before the write
- rf_restore_valid  out  1  register-file restore write enable
- rf_restore_reg  out  REG_IDX_WIDTH  restore index
- rf_restore_data  out  DATA_WIDTH  restore value
- flush  out  1  pipeline flush request
- redirect_valid  out  1  fetch redirect strobe
- redirect_pc  out  ADDR_WIDTH  redirect target (= latched spec_pc)
- recovery_done  out  1  one-cycle completion pulse to predictor
- spec_active  out  1  speculation window open
- log_full  out  1  undo stack full; pipeline must stall speculative writebacks
- log_overflow  out  1  sticky: writeback arrived while full

Behaviour:
- All outputs registered. On rst (async), outputs go to 0, FSM goes to IDLE, count=0, and latched PC=0. Reset mid-UNDO abandons the rollback with no further restore writes.
- States: IDLE, SPEC, UNDO, REDIRECT, DONE.
- IDLE:
  - spec_start -> SPEC. Latch spec_pc, count=0, spec_active=1 from next cycle.
  - wb_valid, recover and correct are ignored.
- SPEC:
  - wb_valid with count<LOG_DEPTH -> push {wb_reg, wb_old_data}, count+1.
  - wb_valid with count==LOG_DEPTH -> entry dropped, log_overflow set (sticky until rst).
  - log_full = (count==LOG_DEPTH), registered.
  - correct -> IDLE, count=0, and any same-cycle wb is not logged.
  - recover -> UNDO, and a same-cycle wb_valid is pushed first (it did modify the RF).
  - recover and correct in the same cycle: recover wins.
  - spec_start while in SPEC is ignored.
- UNDO:
  - Each cycle with count>0: pop top, drive rf_restore_valid=1 with that reg/data, count-1.
  - Leave for REDIRECT the cycle after the last pop. With count==0 on entry, go to REDIRECT immediately, with no restore cycles.
  - All inputs are ignored.
- REDIRECT: redirect_valid=1, redirect_pc=latched PC for one cycle -> DONE.
- DONE: recovery_done=1 for one cycle, spec_active=0 -> IDLE.
- flush=1 from the first cycle after recover through the REDIRECT cycle inclusive.
- Timing, recover sampled at edge T with N logged entries (N includes any same-cycle push):
  - restores occur at cycles T+1..T+N
  - redirect_valid at T+N+1
  - recovery_done at T+N+2
  - flush high T+1..T+N+1
- Stack pointer: stack pointer arithmetic is mod LOG_DEPTH; count has width log2(LOG_DEPTH)+1. Pop order is strictly reverse of push order.
- Duplicate registers in the log are legal. Restoring LIFO leaves the oldest value, which is correct.

Test Plan:
- Correct path: spec_start pc=0x0040_0010, 2 wb pushes, correct -> IDLE next cycle; no restore, flush or redirect; recovery_done stays 0.
- Mispredict 3 entries: push (r4,0x11),(r5,0x22),(r4,0x33), recover at T -> restores at T+1..T+3 of (r4,0x33),(r5,0x22),(r4,0x11); redirect_pc=0x0040_0010 at T+4; recovery_done at T+5; flush T+1..T+4.
- Empty log: spec_start then recover at T -> no restore, redirect at T+1, recovery_done at T+2.
- Full log: LOG_DEPTH=8, 9 wb pushes -> log_full=1 after 8th; 9th dropped, log_overflow=1; recover produces exactly 8 restores.
- Simultaneous: recover and wb_valid (r7,0x77) in same cycle with 1 prior entry (r2,0x5) -> restores (r7,0x77) then (r2,0x5). recover+correct same cycle -> UNDO taken.
- Reset mid-UNDO: assert rst after first of 3 restores -> all outputs 0 immediately; no further restores; IDLE accepts new spec_start.
